systolic_output_controller: RTL and testbench
=============================================

// Module: systolic_output_controller
// PURPOSE
//  Output-side counterpart of the systolic input skew controller. After an output-stationary
//  ROWS x COLS array finishes a tile, it drains the array one column per cycle. Row lanes
//  arrive diagonally skewed: lane i lags lane 0 by i cycles.
//  This block removes that skew, buffers the aligned column words and presents them
//  downstream on a valid/ready stream.
// PARAMETERS
//  ACC_WIDTH  32  signed accumulator width per lane
//  ROWS       4   array rows = lanes per output word (>=2)
//  COLS       4   array columns = words per tile (>=1)
//  FIFO_DEPTH 8   output buffer entries; power of 2, >= COLS
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               asynchronous, active-high reset
//  start      in   1               pulse: begin draining one tile
//  busy       out  1               high in any state except IDLE
//  done       out  1               1-cycle pulse: last word of tile consumed
//  drain_en   out  1               to array: shift one result column out per cycle
//  in_data    in   ACC_WIDTH*ROWS  lane i at [(i+1)*ACC_WIDTH-1 -: ACC_WIDTH], skewed
//  in_valid   in   ROWS            per-lane valid, skewed like in_data
//  out_data   out  ACC_WIDTH*ROWS  aligned column word, same lane packing
//  out_valid  out  1               out_data valid
//  out_ready  in   1               consumer accepts when out_valid & out_ready
//  out_last   out  1               qualifies the COLS-th word of the tile
//  err_skew   out  1               sticky: aligned valids disagreed
// BEHAVIOUR
//  Reset (async): state=IDLE, FIFO empty, delay lines cleared, counters 0.
//   All outputs are 0; out_data is 0.
//  FSM:
//   IDLE -> WAIT_SPACE when start=1. start is ignored in every other state.
//   WAIT_SPACE -> DRAIN when FIFO free entries >= COLS.
//    This reserves space, so the array is never back-pressured.
//   DRAIN: drain_en=1 for exactly COLS cycles, then -> FLUSH.
//   FLUSH: ROWS cycles, letting the skewed tail and the align stage settle; then -> WAIT_POP.
//   WAIT_POP: wait until COLS words of this tile are popped. Then done=1 for 1 cycle -> IDLE.
//  De-skew datapath:
//   - Lane i passes through ROWS-1-i registers, then a common align register.
//   - Data values are unchanged (no arithmetic, no sign change).
//   - Each cycle, the align register holds a valid-bit vector.
//   - If the vector is all ones, the word is pushed into the FIFO.
//   - If it is all zeros, nothing is pushed.
//   - If it is mixed, nothing is pushed and err_skew is set.
//   - err_skew is cleared only by reset or by an accepted start.
//  Latency:
//   - A lane-0 element sampled at edge E appears on out_data with out_valid=1 just after
//     edge E+ROWS, provided the FIFO was empty.
//   - The FIFO is first-word-fall-through.
//  Stream rules:
//   - out_data and out_valid hold while out_valid & ~out_ready.
//   - A pop and a push in the same cycle are both honoured.
//   - The count is unchanged when both occur.
//   - out_last is computed from a per-tile pop counter (0..COLS-1).
//  Boundaries:
//   - A push is never attempted while full; the reservation guarantees this.
//   - If a push hits a full FIFO anyway, the word is dropped and err_skew is set.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - out_ready may stay low indefinitely; the FSM holds in WAIT_POP.
//   - A new tile may start (IDLE->WAIT_SPACE) only after done.
//   - in_valid outside DRAIN/FLUSH windows is still de-skewed and pushed.
//     The array must not raise it in those windows.
//   - Reset mid-DRAIN: drain_en drops immediately (async). FIFO contents are discarded.
// STRUCTURE
//  Shared package sys_pkg:
//   - state enum {IDLE, WAIT_SPACE, DRAIN, FLUSH, WAIT_POP}
//   - lane-slice helper function
//   - default ACC_WIDTH
//  Sub-module sys_fwft_fifo (WIDTH, DEPTH): async active-high reset.
//   Ports: push, pop, full, empty, count.
//  Top level holds the FSM, delay lines, align stage and counters.
// TESTING (ROWS=4, COLS=4, ACC_WIDTH=32, FIFO_DEPTH=8)
//  1. Basic drain:
//     - Stimulus: start. Feed the skewed columns [1,2,3,4],[5,6,7,8],[9,10,11,12],
//       [13,14,15,16] with out_ready=1.
//     - Response: out_data words [1,2,3,4]..[13,14,15,16] in order, out_last on the
//       4th word, one done pulse, busy=0 afterwards.
//  2. Latency:
//     - Stimulus: lane-0 valid sampled at edge E.
//     - Response: first out_valid=1 right after edge E+4. drain_en is high for exactly
//       4 cycles.
//  3. Backpressure:
//     - Stimulus: out_ready=0 for the whole drain, then 1.
//     - Response: 4 words held intact. done only after the 4th pop. No err_skew.
//  4. Reservation:
//     - Stimulus: leave 6 words unread, then start.
//     - Response: FSM stays in WAIT_SPACE and drain_en=0 until the consumer pops >= 2.
//  5. Skew error:
//     - Stimulus: drive lane 2 one cycle late.
//     - Response: err_skew=1, the mis-aligned word is not pushed, err_skew stays set until
//       the next start.
//  6. Reset mid-DRAIN:
//     - Stimulus: assert rst on the 2nd drain cycle.
//     - Response: all outputs 0 immediately. After release, a clean test-1 run passes;
//       negative values (e.g. -5) are passed through bit-exact.

Source files
------------

// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_pkg
// Description : Shared definitions for the systolic output path. Holds the
//               controller state encoding, the default accumulator width and
//               a helper that locates a lane inside a packed multi-lane word.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_pkg;

    localparam int c_ACC_WIDTH = 32;

    // Controller state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_IDLE       = 3'd0;
    localparam state_t c_WAIT_SPACE = 3'd1;
    localparam state_t c_DRAIN      = 3'd2;
    localparam state_t c_FLUSH      = 3'd3;
    localparam state_t c_WAIT_POP   = 3'd4;

    // LSB position of lane 'lane' in a word packed as lane i at
    // [(i+1)*width-1 -: width]; use with a '+: width' part-select.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sys_fwft_fifo
// Description : First-word-fall-through FIFO. The head entry is visible on
//               pop_data whenever the FIFO is non-empty; pop_data reads 0
//               when empty. Simultaneous push and pop are both honoured.
//               A push while full or a pop while empty is ignored.
// Ports       : clk, rst (async, active-high)
//               push / push_data  - write one entry
//               pop  / pop_data   - consume head entry / head entry value
//               full, empty, count (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sys_fwft_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8          // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage carries no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full     = (r_count == (c_AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/systolic_output_controller.sv
`default_nettype none
// ============================================================================
// Module      : systolic_output_controller
// Description : Drains an output-stationary ROWS x COLS systolic array one
//               column per cycle, removes the diagonal lane skew (lane i lags
//               lane 0 by i cycles), buffers aligned column words in a FWFT
//               FIFO and presents them on a valid/ready stream.
// Ports       : clk, rst (async, active-high)
//               start      - pulse, begin draining one tile (IDLE only)
//               busy       - controller not in IDLE
//               done       - 1-cycle pulse once the tile's last word is popped
//               drain_en   - to array: shift one result column per cycle
//               in_data    - skewed lanes, lane i at [(i+1)*ACC_WIDTH-1 -: ACC_WIDTH]
//               in_valid   - per-lane valid, skewed like in_data
//               out_data   - aligned column word, same lane packing
//               out_valid / out_ready - output handshake
//               out_last   - marks the COLS-th word of the tile
//               err_skew   - sticky, aligned valids disagreed or word dropped
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_output_controller
    import sys_pkg::*;
#(
    parameter int ACC_WIDTH  = c_ACC_WIDTH,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      drain_en,
    input  logic [ACC_WIDTH*ROWS-1:0] in_data,
    input  logic [ROWS-1:0]           in_valid,
    output logic [ACC_WIDTH*ROWS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      err_skew
);

    localparam int c_DW      = ACC_WIDTH * ROWS;
    localparam int c_CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int c_CNT_MAX = (COLS > ROWS) ? COLS : ROWS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_POP_W   = (COLS > 1) ? $clog2(COLS) : 1;

    // ------------------------------------------------------------------
    // De-skew: lane i gets ROWS-1-i delay registers so every lane of a
    // column lines up; the last lane feeds the align stage directly.
    // ------------------------------------------------------------------
    logic [c_DW-1:0] w_tap_data;
    logic [ROWS-1:0] w_tap_valid;

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        localparam int c_DEPTH = ROWS - 1 - i;
        if (c_DEPTH == 0) begin : g_direct
            assign w_tap_data[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH] =
                in_data[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH];
            assign w_tap_valid[i] = in_valid[i];
        end else begin : g_delay
            logic [ACC_WIDTH-1:0] r_d [c_DEPTH];
            logic [c_DEPTH-1:0]   r_v;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < c_DEPTH; k++) begin
                        r_d[k] <= '0;
                    end
                    r_v <= '0;
                end else begin
                    r_d[0] <= in_data[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH];
                    r_v[0] <= in_valid[i];
                    for (int k = 1; k < c_DEPTH; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                    end
                end
            end
            assign w_tap_data[lane_lsb(i, ACC_WIDTH) +: ACC_WIDTH] = r_d[c_DEPTH-1];
            assign w_tap_valid[i] = r_v[c_DEPTH-1];
        end
    end

    logic [c_DW-1:0] r_align_data;
    logic [ROWS-1:0] r_align_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_align_data  <= '0;
            r_align_valid <= '0;
        end else begin
            r_align_data  <= w_tap_data;
            r_align_valid <= w_tap_valid;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    logic            w_all_valid;
    logic            w_any_valid;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_err;
    logic [c_CW-1:0] w_count;

    assign w_all_valid = &r_align_valid;
    assign w_any_valid = |r_align_valid;
    assign w_push      = w_all_valid & ~w_full;
    // A partial valid vector or a word that finds the buffer full is an error.
    assign w_err       = (w_any_valid & ~w_all_valid) | (w_all_valid & w_full);
    assign out_valid   = ~w_empty;
    assign w_pop       = out_valid & out_ready;

    sys_fwft_fifo #(
        .WIDTH (c_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_align_data),
        .pop       (w_pop),
        .pop_data  (out_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CW-1:0]    r_ahead;      // words queued before this tile's first word
    logic [c_POP_W-1:0] r_pop_cnt;    // pops of this tile, 0..COLS-1
    logic               r_tile_done;
    logic               r_err;
    logic               w_space_ok;
    logic               w_in_tile;
    logic               w_start_acc;
    logic               w_enter_drain;

    // Reserving COLS free entries before draining means the array never
    // needs to be stalled.
    assign w_space_ok    = (c_CW'(FIFO_DEPTH) - w_count) >= c_CW'(COLS);
    assign w_in_tile     = (r_state == c_DRAIN) || (r_state == c_FLUSH) ||
                           (r_state == c_WAIT_POP);
    assign w_start_acc   = (r_state == c_IDLE) && start;
    assign w_enter_drain = (r_state == c_WAIT_SPACE) && (w_state_nxt == c_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != c_IDLE);
        drain_en    = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_WAIT_SPACE;
                end
            end
            c_WAIT_SPACE: begin
                if (w_space_ok) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                drain_en = 1'b1;
                if (r_cnt == c_CNT_W'(COLS - 1)) begin
                    w_state_nxt = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (r_cnt == c_CNT_W'(ROWS - 1)) begin
                    w_state_nxt = c_WAIT_POP;
                end
            end
            c_WAIT_POP: begin
                if (r_tile_done) begin
                    done        = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Cycle counter shared by DRAIN and FLUSH; restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != w_state_nxt) begin
            r_cnt <= '0;
        end else if ((r_state == c_DRAIN) || (r_state == c_FLUSH)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Tile pop tracking. Words already buffered when draining begins belong
    // to earlier traffic, so they are skipped before counting tile pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ahead     <= '0;
            r_pop_cnt   <= '0;
            r_tile_done <= 1'b0;
        end else if (w_enter_drain) begin
            r_ahead     <= w_count - c_CW'(w_pop);
            r_pop_cnt   <= '0;
            r_tile_done <= 1'b0;
        end else if (done) begin
            r_tile_done <= 1'b0;
        end else if (w_in_tile && w_pop) begin
            if (r_ahead != '0) begin
                r_ahead <= r_ahead - c_CW'(1);
            end else if (r_pop_cnt == c_POP_W'(COLS - 1)) begin
                r_pop_cnt   <= '0;
                r_tile_done <= 1'b1;
            end else begin
                r_pop_cnt <= r_pop_cnt + c_POP_W'(1);
            end
        end
    end

    assign out_last = out_valid && w_in_tile && (r_ahead == '0) && !r_tile_done &&
                      (r_pop_cnt == c_POP_W'(COLS - 1));

    // Sticky error; an accepted start clears it, a same-cycle error re-arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_err & ~w_start_acc) | w_err;
        end
    end

    assign err_skew = r_err;

endmodule
`default_nettype wire

// File: tb/tb_systolic_output_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_output_controller
// Description : Self-checking bench for systolic_output_controller with
//               ROWS=4, COLS=4, ACC_WIDTH=32, FIFO_DEPTH=8. Expected words
//               are queued when skewed columns are driven and compared as the
//               consumer pops them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_output_controller;

    localparam int c_ROWS  = 4;
    localparam int c_COLS  = 4;
    localparam int c_W     = 32;
    localparam int c_DEPTH = 8;
    localparam int c_DW    = c_W * c_ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start;
    logic              busy;
    logic              done;
    logic              drain_en;
    logic [c_DW-1:0]   in_data;
    logic [c_ROWS-1:0] in_valid;
    logic [c_DW-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              err_skew;

    always #5 clk = ~clk;

    systolic_output_controller #(
        .ACC_WIDTH  (c_W),
        .ROWS       (c_ROWS),
        .COLS       (c_COLS),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .drain_en  (drain_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .err_skew  (err_skew)
    );

    typedef struct packed {
        logic [c_DW-1:0] data;
        logic            last;
    } exp_t;

    exp_t         sb[$];
    logic [31:0]  tile [8][c_ROWS];
    int           errors    = 0;
    int           checks    = 0;
    int           cyc       = 0;
    int           rise_cyc  = -1;
    int           done_cnt  = 0;
    int           drain_cnt = 0;
    logic         prev_ov   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: every accepted word is checked against the queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (drain_en) drain_cnt++;
            if (done) done_cnt++;
            if (out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: got data=%h last=%b, required no word", out_data, out_last);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_last !== e.last) begin
                        errors++;
                        $display("FAIL pop_word: got data=%h last=%b, required data=%h last=%b",
                                 out_data, out_last, e.data, e.last);
                    end
                end
            end
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (drain_en !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (drain_en !== 1'b1) begin
            errors++;
            $display("FAIL drain_start: drain_en=%b, required 1 within %0d cycles", drain_en, budget);
        end
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (done_cnt !== base + 1) begin
            errors++;
            $display("FAIL done_pulse: done pulses=%0d, required %0d", done_cnt - base, 1);
        end
    endtask

    // Drive ncols columns from 'tile' with lane i lagging lane 0 by i cycles;
    // late_lane (>=0) is delayed by one extra cycle and then no word is expected.
    task automatic feed(input int ncols, input int late_lane, input int last_col);
        exp_t e;
        if (late_lane < 0) begin
            for (int c = 0; c < ncols; c++) begin
                for (int i = 0; i < c_ROWS; i++) e.data[i*c_W +: c_W] = tile[c][i];
                e.last = (c == last_col);
                sb.push_back(e);
            end
        end
        for (int t = 0; t < ncols + c_ROWS - 1 + ((late_lane >= 0) ? 1 : 0); t++) begin
            for (int i = 0; i < c_ROWS; i++) begin
                int cc;
                cc = t - i - ((i == late_lane) ? 1 : 0);
                if (cc >= 0 && cc < ncols) begin
                    in_data[i*c_W +: c_W] = tile[cc][i];
                    in_valid[i] = 1'b1;
                end else begin
                    in_data[i*c_W +: c_W] = '0;
                    in_valid[i] = 1'b0;
                end
            end
            step(1);
        end
        in_data  = '0;
        in_valid = '0;
    endtask

    task automatic fill_tile(input int ncols, input int base);
        for (int c = 0; c < ncols; c++)
            for (int i = 0; i < c_ROWS; i++)
                tile[c][i] = 32'(base + c * c_ROWS + i);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(3);
        checks++;
        if ({busy, done, drain_en, out_valid, out_last, err_skew} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy,done,drain,ov,last,err=%b, required 000000",
                     {busy, done, drain_en, out_valid, out_last, err_skew});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", out_data);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        int base_done  = done_cnt;
        int base_drain = drain_cnt;
        int d;
        out_ready = 1'b1;
        fill_tile(c_COLS, 1);
        do_start();
        wait_drain(10);
        d = cyc;
        feed(c_COLS, -1, c_COLS - 1);
        wait_done(base_done, 40);
        checks++;
        if (drain_cnt - base_drain !== c_COLS) begin
            errors++;
            $display("FAIL basic_drain_len: got %0d cycles, required %0d", drain_cnt - base_drain, c_COLS);
        end
        checks++;
        if (rise_cyc !== d + c_ROWS + 1) begin
            errors++;
            $display("FAIL basic_latency: first out_valid at cycle %0d, required %0d", rise_cyc, d + c_ROWS + 1);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL basic_words: %0d words left, required 0", sb.size());
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        int base_done = done_cnt;
        logic [c_DW-1:0] head;
        out_ready = 1'b0;
        fill_tile(c_COLS, 32'h100);
        do_start();
        wait_drain(10);
        feed(c_COLS, -1, c_COLS - 1);
        step(3);
        head = sb[0].data;
        checks++;
        if (out_valid !== 1'b1 || out_data !== head) begin
            errors++;
            $display("FAIL bp_head: got valid=%b data=%h, required 1 %h", out_valid, out_data, head);
        end
        checks++;
        if (busy !== 1'b1 || done_cnt !== base_done) begin
            errors++;
            $display("FAIL bp_wait: got busy=%b dones=%0d, required 1 0", busy, done_cnt - base_done);
        end
        step(4);
        checks++;
        if (out_data !== head) begin
            errors++;
            $display("FAIL bp_hold: got %h, required %h", out_data, head);
        end
        out_ready = 1'b1;
        wait_done(base_done, 20);
        checks++;
        if (sb.size() !== 0 || err_skew !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: got left=%0d err=%b, required 0 0", sb.size(), err_skew);
        end
    endtask

    task automatic test_reservation();
        int base_done  = done_cnt;
        int base_drain = drain_cnt;
        out_ready = 1'b0;
        fill_tile(6, 32'h200);
        feed(6, -1, -1);
        step(2);
        do_start();
        step(4);
        checks++;
        if (busy !== 1'b1 || drain_en !== 1'b0 || drain_cnt !== base_drain) begin
            errors++;
            $display("FAIL resv_hold6: got busy=%b drain=%b, required 1 0", busy, drain_en);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(3);
        checks++;
        if (drain_en !== 1'b0) begin
            errors++;
            $display("FAIL resv_hold5: got drain_en=%b, required 0", drain_en);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        wait_drain(5);
        fill_tile(c_COLS, 32'h300);
        feed(c_COLS, -1, c_COLS - 1);
        step(3);
        out_ready = 1'b1;
        wait_done(base_done, 40);
        checks++;
        if (sb.size() !== 0 || err_skew !== 1'b0) begin
            errors++;
            $display("FAIL resv_end: got left=%0d err=%b, required 0 0", sb.size(), err_skew);
        end
    endtask

    task automatic test_skew();
        int base_done = done_cnt;
        out_ready = 1'b1;
        fill_tile(1, 32'h400);
        feed(1, 2, -1);
        step(2);
        checks++;
        if (err_skew !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skew_flag: got err=%b valid=%b, required 1 0", err_skew, out_valid);
        end
        step(5);
        checks++;
        if (err_skew !== 1'b1) begin
            errors++;
            $display("FAIL skew_sticky: got err=%b, required 1", err_skew);
        end
        do_start();
        checks++;
        if (err_skew !== 1'b0) begin
            errors++;
            $display("FAIL skew_clear: got err=%b, required 0", err_skew);
        end
        wait_drain(10);
        fill_tile(c_COLS, 32'h500);
        feed(c_COLS, -1, c_COLS - 1);
        wait_done(base_done, 40);
    endtask

    task automatic test_reset_mid_drain();
        int base_done;
        out_ready = 1'b1;
        do_start();
        wait_drain(10);
        in_data[c_W-1:0] = 32'hAAAA_5555;
        in_valid = 4'b0001;
        step(1);
        in_valid = '0;
        in_data  = '0;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, drain_en, out_valid, out_last, err_skew} !== 6'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_async: got ctrl=%b data=%h, required 000000 0",
                     {busy, done, drain_en, out_valid, out_last, err_skew}, out_data);
        end
        step(1);
        rst = 1'b0;
        step(1);
        base_done = done_cnt;
        for (int c = 0; c < c_COLS; c++)
            for (int i = 0; i < c_ROWS; i++)
                tile[c][i] = 32'(-(c * c_ROWS + i + 1));
        do_start();
        wait_drain(10);
        feed(c_COLS, -1, c_COLS - 1);
        wait_done(base_done, 40);
        checks++;
        if (sb.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_rerun: got left=%0d busy=%b, required 0 0", sb.size(), busy);
        end
    endtask

    initial begin
        start     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reservation();
        test_skew();
        test_reset_mid_drain();
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
